// File: rtl/nx_common_pkg.sv
// Shared definitions for the nx_* stream blocks.
// Holds the two-state controller encoding used by the serialiser.
package nx_common;

    // IDLE: no message held; SEND: message held with chunks still pending.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } nx_state_e;

endpackage : nx_common

// File: rtl/nx_stream_serialiser.sv
// nx_stream_serialiser: splits one STREAM_WIDTH message into
// STREAM_WIDTH/CHUNK_WIDTH chunks on a valid/ready stream.
// Chunk order is LSB chunk first by default; defining the macro
// NX_STREAM_SERIALISER_MSB_FIRST_EN switches to MSB chunk first.
// All outbound signals are registered; a new message is loaded in the
// same cycle the last chunk leaves, giving a sustained 1 chunk/cycle.
module nx_stream_serialiser
    import nx_common::*;
#(
    parameter int STREAM_WIDTH = 32,
    parameter int CHUNK_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [STREAM_WIDTH-1:0] inbound_data_i,
    input  logic                    inbound_valid_i,
    output logic                    inbound_ready_o,
    output logic [CHUNK_WIDTH-1:0]  outbound_data_o,
    output logic                    outbound_last_o,
    output logic                    outbound_valid_o,
    input  logic                    outbound_ready_i,
    output logic                    idle_o
);

    localparam int NUM_CHUNKS = STREAM_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHUNKS - 1);

    // Reject widths that do not split into a whole number of chunks.
    generate
        if ((NUM_CHUNKS < 1) || ((STREAM_WIDTH % CHUNK_WIDTH) != 0)) begin : g_bad_width
            $error("nx_stream_serialiser: STREAM_WIDTH must be a non-zero multiple of CHUNK_WIDTH");
        end
    endgenerate

    // Chunk k of a message in the configured emission order.
    function automatic logic [CHUNK_WIDTH-1:0] chunk_sel(
        input logic [STREAM_WIDTH-1:0] msg,
        input int                      k
    );
`ifdef NX_STREAM_SERIALISER_MSB_FIRST_EN
        return CHUNK_WIDTH'(msg >> ((NUM_CHUNKS - 1 - k) * CHUNK_WIDTH));
`else
        return CHUNK_WIDTH'(msg >> (k * CHUNK_WIDTH));
`endif
    endfunction

    nx_state_e                 r_state;
    logic [STREAM_WIDTH-1:0]   r_hold;
    logic [CNT_W-1:0]          r_cnt;
    logic [CHUNK_WIDTH-1:0]    r_data;
    logic                      r_last;
    logic                      r_valid;

    logic                      w_out_hs;
    logic                      w_last_hs;
    logic                      w_in_hs;
    logic [CNT_W-1:0]          w_cnt_nxt;

    // Handshake decode; ready only when nothing will be pending after this cycle.
    assign w_out_hs        = r_valid && outbound_ready_i;
    assign w_last_hs       = w_out_hs && r_last;
    assign inbound_ready_o = !rst_i && ((r_state == IDLE) || w_last_hs);
    assign w_in_hs         = inbound_valid_i && inbound_ready_o;
    assign w_cnt_nxt       = r_cnt + CNT_W'(1);

    // Controller: load on inbound accept, step chunks on outbound accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_in_hs) begin
            r_state <= SEND;
            r_hold  <= inbound_data_i;
            r_cnt   <= '0;
            r_data  <= chunk_sel(inbound_data_i, 0);
            r_last  <= (NUM_CHUNKS == 1);
            r_valid <= 1'b1;
        end else if (w_last_hs) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_out_hs) begin
            r_cnt   <= w_cnt_nxt;
            r_data  <= chunk_sel(r_hold, int'(w_cnt_nxt));
            r_last  <= (w_cnt_nxt == LAST_IDX);
        end
    end

    assign outbound_data_o  = r_data;
    assign outbound_last_o  = r_last;
    assign outbound_valid_o = r_valid;
    assign idle_o           = (r_state == IDLE);

endmodule : nx_stream_serialiser

// File: tb/tb_nx_stream_serialiser.sv
// Bench for nx_stream_serialiser: a 32/8 instance driven by directed
// scenarios and random traffic against a queue-based reference model,
// plus an 8/8 instance for the single-chunk case. Chunk order follows
// NX_STREAM_SERIALISER_MSB_FIRST_EN exactly as the design does.
module tb_nx_stream_serialiser;

    localparam int SW = 32;
    localparam int CW = 8;
    localparam int NC = SW / CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          idle;

    logic [7:0]    in_data1 = '0;
    logic          in_valid1 = 1'b0;
    logic          in_ready1;
    logic [7:0]    out_data1;
    logic          out_last1;
    logic          out_valid1;
    logic          out_ready1 = 1'b1;
    logic          idle1;

    always #5 clk = ~clk;

    nx_stream_serialiser #(.STREAM_WIDTH(SW), .CHUNK_WIDTH(CW)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .inbound_data_i(in_data), .inbound_valid_i(in_valid), .inbound_ready_o(in_ready),
        .outbound_data_o(out_data), .outbound_last_o(out_last),
        .outbound_valid_o(out_valid), .outbound_ready_i(out_ready),
        .idle_o(idle)
    );

    nx_stream_serialiser #(.STREAM_WIDTH(8), .CHUNK_WIDTH(8)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .inbound_data_i(in_data1), .inbound_valid_i(in_valid1), .inbound_ready_o(in_ready1),
        .outbound_data_o(out_data1), .outbound_last_o(out_last1),
        .outbound_valid_o(out_valid1), .outbound_ready_i(out_ready1),
        .idle_o(idle1)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: chunks still owed, each {last, data}.
    logic [8:0]  q_exp [$];
    logic [7:0]  q_log [$];
    bit          post_rst = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    logic        prev_last = 1'b0;
    bit          acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Message m as the ordered list of chunks it must produce.
    task automatic model_push(input logic [SW-1:0] m);
        for (int k = 0; k < NC; k++) begin
            int idx;
            logic [7:0] c;
`ifdef NX_STREAM_SERIALISER_MSB_FIRST_EN
            idx = NC - 1 - k;
`else
            idx = k;
`endif
            c = 8'((m >> (idx * CW)) & 32'hFF);
            q_exp.push_back({(k == NC - 1), c});
        end
    endtask

    // Sampled on the falling edge: inputs are settled, outputs reflect state.
    task automatic monitor();
        logic [8:0] e;
        acc = 1'b0;
        if (rst) begin
            chk("rst_in_ready", in_ready, 1'b0);
            q_exp.delete();
            prev_stall = 1'b0;
            post_rst = 1'b1;
            return;
        end
        if (post_rst) begin
            chk("rst_valid", out_valid, 1'b0);
            chk("rst_last", out_last, 1'b0);
            chk("rst_data", out_data, 8'h00);
            chk("rst_idle", idle, 1'b1);
            post_rst = 1'b0;
        end
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, prev_data);
            chk("stall_last", out_last, prev_last);
        end
        chk("valid_vs_pending", out_valid, (q_exp.size() != 0));
        chk("idle_vs_pending", idle, (q_exp.size() == 0));
        if (out_valid && out_ready && (q_exp.size() != 0)) begin
            e = q_exp.pop_front();
            chk("chunk_data", out_data, e[7:0]);
            chk("chunk_last", out_last, e[8]);
            q_log.push_back(out_data);
        end
        chk("in_ready", in_ready, (q_exp.size() == 0));
        if (in_valid && in_ready) begin
            model_push(in_data);
            acc = 1'b1;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [SW-1:0] m);
        in_data  = m;
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step();
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic check_log(input string tag, input logic [7:0] exp [$]);
        chk({tag, "_count"}, q_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < q_log.size(); i++)
            chk(tag, q_log[i], exp[i]);
        q_log.delete();
    endtask

    initial begin
        logic [7:0] e33 [$];
        logic [7:0] e34 [$];
        logic [7:0] e35 [$];
        logic [7:0] e36 [$];
`ifdef NX_STREAM_SERIALISER_MSB_FIRST_EN
        e33 = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        e34 = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
        e35 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        e36 = '{8'h00, 8'h00, 8'h00, 8'h01};
`else
        e33 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        e34 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        e35 = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hCC, 8'hBB, 8'hAA, 8'h99};
        e36 = '{8'h01, 8'h00, 8'h00, 8'h00};
`endif
        #1;
        idle_steps(2);
        rst = 1'b0;
        step();

        // Single-chunk instance: one chunk, marked last, then idle again.
        in_valid1 = 1'b1;
        in_data1  = 8'h5A;
        @(negedge clk);
        chk("w8_idle0", idle1, 1'b1);
        chk("w8_ready0", in_ready1, 1'b1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        chk("w8_valid", out_valid1, 1'b1);
        chk("w8_data", out_data1, 8'h5A);
        chk("w8_last", out_last1, 1'b1);
        chk("w8_busy", idle1, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w8_valid_after", out_valid1, 1'b0);
        chk("w8_idle_after", idle1, 1'b1);
        @(posedge clk); #1;

        // Single message, sink always ready.
        q_log.delete();
        out_ready = 1'b1;
        send(32'hDDCCBBAA);
        idle_steps(6);
        check_log("msg_ddccbbaa", e33);

        // Back-to-back messages with inbound valid held high.
        send(32'h04030201);
        send(32'h08070605);
        idle_steps(6);
        check_log("back_to_back", e34);

        // Sink stalls for three cycles on chunk 1 while the next message waits.
        send(32'h11223344);
        in_valid = 1'b1;
        in_data  = 32'h99AABBCC;
        step();
        out_ready = 1'b0;
        idle_steps(3);
        out_ready = 1'b1;
        send(32'h99AABBCC);
        idle_steps(6);
        check_log("stall", e35);

        // Reset mid-message discards the rest of it.
        send(32'hA5A5A5A5);
        idle_steps(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        q_log.delete();
        send(32'h00000001);
        idle_steps(6);
        check_log("after_reset", e36);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            in_data   = $urandom;
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle_steps(8);
        chk("drained", q_exp.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_nx_stream_serialiser

// File: doc/nx_stream_serialiser.md
NX_STREAM_SERIALISER -- requirements
Module: nx_stream_serialiser

Interface
REQ-001 SHALL have parameter STREAM_WIDTH, default 32: width of the wide inbound message.
REQ-002 SHALL have parameter CHUNK_WIDTH, default 8: width of each outbound chunk.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port inbound_data_i  input  STREAM_WIDTH  wide message.
REQ-006 SHALL have port inbound_valid_i  input  1  wide message present.
REQ-007 SHALL have port inbound_ready_o  output  1  wide message accepted when high with valid.
REQ-008 SHALL have port outbound_data_o  output  CHUNK_WIDTH  current chunk.
REQ-009 SHALL have port outbound_last_o  output  1  current chunk is the final chunk of its message.
REQ-010 SHALL have port outbound_valid_o  output  1  chunk present.
REQ-011 SHALL have port outbound_ready_i  input  1  chunk accepted when high with valid.
REQ-012 SHALL have port idle_o  output  1  no message held.

Function
REQ-013 SHALL define NUM_CHUNKS = STREAM_WIDTH / CHUNK_WIDTH; a non-zero remainder SHALL be a compile-time error.
REQ-014 SHALL implement two states: IDLE (no message held) and SEND (message held, chunks pending).
REQ-015 SHALL drive inbound_ready_o high in IDLE, and in SEND only in a cycle where the last chunk completes its handshake.
REQ-016 SHALL, on an inbound handshake in cycle N, capture inbound_data_i, zero the chunk counter, and enter or remain in SEND, presenting chunk 0 with outbound_valid_o high in cycle N+1.
REQ-017 SHALL advance the chunk counter by one on each outbound handshake (outbound_valid_o && outbound_ready_i).
REQ-018 SHALL drive all outbound signals from registers, with no combinational path from inbound_* to outbound_*.
REQ-019 SHALL default chunk k to bits [k*CHUNK_WIDTH +: CHUNK_WIDTH] (LSB chunk first).
REQ-020 SHALL assert outbound_last_o exactly when the counter equals NUM_CHUNKS-1; with NUM_CHUNKS==1, every chunk is last.
REQ-021 SHALL hold outbound_data_o and outbound_last_o stable while outbound_valid_o is high and outbound_ready_i is low.
REQ-022 SHALL, when the last-chunk handshake and an inbound handshake coincide, load the new message with no bubble, so chunk 0 follows in the next cycle (sustained 1 chunk/cycle).
REQ-023 SHALL return to IDLE on a last-chunk handshake without a simultaneous inbound handshake, with outbound_valid_o low in the next cycle.
REQ-024 SHALL size the counter as max(1, $clog2(NUM_CHUNKS)) bits; it SHALL never exceed NUM_CHUNKS-1.
REQ-025 SHALL drive idle_o high exactly when the state is IDLE.

Reset
REQ-026 SHALL, while rst_i is high at a clock edge, enter IDLE with holding register = 0, counter = 0, outbound_valid_o = 0, outbound_last_o = 0, outbound_data_o = 0 and idle_o = 1.
REQ-027 SHALL, on reset mid-message, discard remaining chunks and emit no further chunk of that message.
REQ-028 SHALL hold inbound_ready_o low while rst_i is high.

Configuration
REQ-029 SHALL, when macro NX_STREAM_SERIALISER_MSB_FIRST_EN is defined, emit chunk k from bits [(NUM_CHUNKS-1-k)*CHUNK_WIDTH +: CHUNK_WIDTH] (MSB chunk first); all other behaviour SHALL be unchanged.
REQ-030 SHALL, when NX_STREAM_SERIALISER_MSB_FIRST_EN is not defined, use LSB-first order per REQ-019.

Structure
REQ-031 SHALL place the state enum (IDLE, SEND) in the shared nx_common package; the NUM_CHUNKS and counter-width localparams SHALL remain local.
REQ-032 SHALL use no sub-module; chunk selection SHALL be a shift or indexed part-select of the holding register.

Verification
REQ-033 SHALL cover: 32/8, LSB-first, inbound 0xDDCCBBAA, outbound_ready_i always high -> chunks 0xAA, 0xBB, 0xCC, 0xDD in 4 consecutive cycles starting 1 cycle after accept, last on 0xDD only.
REQ-034 SHALL cover: back-to-back messages 0x04030201 then 0x08070605, both valid continuously -> 8 consecutive chunks 0x01..0x08, no bubble, inbound_ready_o high only in accept cycles.
REQ-035 SHALL cover: outbound_ready_i low for 3 cycles on chunk 1 of 0x11223344 -> 0x33 held stable with valid high, no inbound accept, sequence then resumes.
REQ-036 SHALL cover: rst_i pulsed after chunk 1 of 0xA5A5A5A5 -> next cycle outbound_valid_o = 0 and idle_o = 1; new message 0x00000001 then yields 0x01, 0x00, 0x00, 0x00.
REQ-037 SHALL cover: with NX_STREAM_SERIALISER_MSB_FIRST_EN defined, inbound 0xDDCCBBAA -> 0xDD, 0xCC, 0xBB, 0xAA, last on 0xAA.
REQ-038 SHALL cover: STREAM_WIDTH = CHUNK_WIDTH = 8, inbound 0x5A -> single chunk 0x5A with outbound_last_o high, idle_o high in the next cycle.
